// File: rtl/clk_meter.sv
// -----------------------------------------------------------------------------
// clk_meter
//
// Measures a slow, asynchronous input clock (typically a divider output) in
// units of the system clock. Each completed input period produces a one-cycle
// meas_valid strobe together with the high-phase length, the low-phase length
// and their sum. A phase that runs long enough to saturate its counter raises
// stuck, which stays set until the next good measurement.
//
// Parameters:
//   WIDTH       width of the phase counters; longest countable phase is
//               2**WIDTH-1 clk cycles
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   sig_in      slow clock under measurement (asynchronous to clk)
//   high_time   high-phase length of the last completed period
//   low_time    low-phase length of the last completed period
//   period      high_time + low_time, one bit wider so it cannot overflow
//   meas_valid  one-cycle pulse when the three results update
//   stuck       a phase counter saturated; cleared by the next meas_valid
// -----------------------------------------------------------------------------
module clk_meter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] high_time,
  output logic [WIDTH-1:0] low_time,
  output logic [WIDTH:0]   period,
  output logic             meas_valid,
  output logic             stuck
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    SYNC,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  // Synchronizer chain and edge decode
  logic s1, s2, s3;
  logic rise, fall;

  // Measurement state
  state_t           state, state_next;
  logic [1:0]       settle, settle_next;
  logic [WIDTH-1:0] hcnt, hcnt_next;
  logic [WIDTH-1:0] lcnt, lcnt_next;

  // Next values of the registered outputs
  logic [WIDTH-1:0] high_next;
  logic [WIDTH-1:0] low_next;
  logic [WIDTH:0]   period_next;
  logic             valid_next;
  logic             stuck_next;

  // Two flops bring sig_in into the clk domain; s3 is one more cycle of
  // history so edges can be decoded from the settled s2 value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A rise and a fall cannot both be true in the same cycle because they
  // need opposite values of s2.
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Next-state logic. The SYNC state lets the synchronizer fill and then
  // waits for the input to be low, so a high phase already in progress when
  // reset lifts is never measured as a short, partial phase.
  always_comb begin
    state_next  = state;
    settle_next = settle;
    hcnt_next   = hcnt;
    lcnt_next   = lcnt;
    high_next   = high_time;
    low_next    = low_time;
    period_next = period;
    valid_next  = 1'b0;
    stuck_next  = stuck;

    case (state)
      SYNC: begin
        if (settle != 2'd3) begin
          settle_next = settle + 2'd1;
        end else if (!s2) begin
          state_next = WAIT_RISE;
        end
      end

      // Only a rise can start a measurement; a fall seen here belongs to a
      // phase we did not see begin (or one that saturated) and is ignored.
      WAIT_RISE: begin
        if (rise) begin
          hcnt_next  = CNT_ONE;
          state_next = MEAS_HIGH;
        end
      end

      MEAS_HIGH: begin
        if (fall) begin
          lcnt_next  = CNT_ONE;
          state_next = MEAS_LOW;
        end else if (hcnt == CNT_MAX) begin
          stuck_next = 1'b1;
          state_next = WAIT_RISE;
        end else begin
          hcnt_next = hcnt + CNT_ONE;
        end
      end

      // A rise closes the period: publish it and immediately start timing
      // the next high phase so back-to-back periods are all reported.
      MEAS_LOW: begin
        if (rise) begin
          high_next   = hcnt;
          low_next    = lcnt;
          period_next = {1'b0, hcnt} + {1'b0, lcnt};
          valid_next  = 1'b1;
          stuck_next  = 1'b0;
          hcnt_next   = CNT_ONE;
          state_next  = MEAS_HIGH;
        end else if (lcnt == CNT_MAX) begin
          stuck_next = 1'b1;
          state_next = WAIT_RISE;
        end else begin
          lcnt_next = lcnt + CNT_ONE;
        end
      end

      default: begin
        state_next = SYNC;
      end
    endcase
  end

  // State, counters and published results. Reset discards any measurement
  // in progress and clears the reported values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SYNC;
      settle     <= 2'd0;
      hcnt       <= '0;
      lcnt       <= '0;
      high_time  <= '0;
      low_time   <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      state      <= state_next;
      settle     <= settle_next;
      hcnt       <= hcnt_next;
      lcnt       <= lcnt_next;
      high_time  <= high_next;
      low_time   <= low_next;
      period     <= period_next;
      meas_valid <= valid_next;
      stuck      <= stuck_next;
    end
  end

endmodule

// File: tb/tb_clk_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_meter
//
// Drives two clk_meter instances (WIDTH=16 and WIDTH=4) with the same slow
// input and reset. The reference model works on timestamps: it records the
// sampled input at every clk edge, finds the edges where a synchronized rise
// or fall takes effect, and derives each expected result from the distance
// between those edges.
// -----------------------------------------------------------------------------
module tb_clk_meter;

  localparam int NUM_EDGES = 16384;

  logic clk = 1'b0;
  logic rst_n;
  logic sig_in;

  logic [15:0] high_a, low_a;
  logic [16:0] period_a;
  logic        valid_a, stuck_a;
  logic [3:0]  high_b, low_b;
  logic [4:0]  period_b;
  logic        valid_b, stuck_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_num     = 0;

  // Sampled value of sig_in at each edge (0 while reset held the flops)
  bit samp [0:NUM_EDGES-1];

  // Model state per instance: index 0 is WIDTH=16, index 1 is WIDTH=4.
  // mode: 0 = settling after reset, 1 = waiting for a rise, 2 = measuring
  int   max_val [2] = '{65535, 15};
  int   mode    [2];
  int   ready_edge;
  int   rise_e  [2];
  int   fall_e  [2];
  int   exp_h   [2];
  int   exp_l   [2];
  int   exp_p   [2];
  logic exp_v   [2];
  logic exp_s   [2];

  clk_meter #(.WIDTH(16)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .high_time  (high_a),
    .low_time   (low_a),
    .period     (period_a),
    .meas_valid (valid_a),
    .stuck      (stuck_a)
  );

  clk_meter #(.WIDTH(4)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .high_time  (high_b),
    .low_time   (low_b),
    .period     (period_b),
    .meas_valid (valid_b),
    .stuck      (stuck_b)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d",
               tag, edge_num, observed, expected);
    end
  endtask

  function automatic bit sampAt(input int idx);
    return (idx >= 0) ? samp[idx] : 1'b0;
  endfunction

  // Advances the reference model by one clk edge using the inputs that the
  // DUTs sampled on that edge.
  task automatic modelEdge();
    bit r, f;
    if (edge_num >= NUM_EDGES) begin
      $display("[TB] FAIL edge budget exceeded at edge %0d, limit %0d", edge_num, NUM_EDGES);
      $fatal(1, "[TB] edge budget exceeded");
    end
    if (!rst_n) begin
      samp[edge_num] = 1'b0;
      if (edge_num >= 1) samp[edge_num-1] = 1'b0;
      if (edge_num >= 2) samp[edge_num-2] = 1'b0;
      ready_edge = edge_num + 4;
      for (int i = 0; i < 2; i++) begin
        mode[i]  = 0;
        exp_h[i] = 0;
        exp_l[i] = 0;
        exp_p[i] = 0;
        exp_v[i] = 1'b0;
        exp_s[i] = 1'b0;
      end
    end else begin
      samp[edge_num] = sig_in;
      r = sampAt(edge_num-2) && !sampAt(edge_num-3);
      f = !sampAt(edge_num-2) && sampAt(edge_num-3);
      for (int i = 0; i < 2; i++) begin
        exp_v[i] = 1'b0;
        if (mode[i] == 0) begin
          if (edge_num >= ready_edge && !sampAt(edge_num-2)) mode[i] = 1;
        end else if (mode[i] == 1) begin
          if (r) begin
            mode[i]   = 2;
            rise_e[i] = edge_num;
            fall_e[i] = -1;
          end
        end else if (fall_e[i] < 0) begin
          if (f) begin
            fall_e[i] = edge_num;
          end else if (edge_num - rise_e[i] == max_val[i]) begin
            exp_s[i] = 1'b1;
            mode[i]  = 1;
          end
        end else begin
          if (r) begin
            exp_h[i]  = fall_e[i] - rise_e[i];
            exp_l[i]  = edge_num - fall_e[i];
            exp_p[i]  = exp_h[i] + exp_l[i];
            exp_v[i]  = 1'b1;
            exp_s[i]  = 1'b0;
            rise_e[i] = edge_num;
            fall_e[i] = -1;
          end else if (edge_num - fall_e[i] == max_val[i]) begin
            exp_s[i] = 1'b1;
            mode[i]  = 1;
          end
        end
      end
    end
  endtask

  // Compares every output of both instances with the model
  task automatic compareAll();
    checkOutput("valid16",  32'(valid_a),  32'(exp_v[0]));
    checkOutput("stuck16",  32'(stuck_a),  32'(exp_s[0]));
    checkOutput("high16",   32'(high_a),   32'(exp_h[0]));
    checkOutput("low16",    32'(low_a),    32'(exp_l[0]));
    checkOutput("period16", 32'(period_a), 32'(exp_p[0]));
    checkOutput("valid4",   32'(valid_b),  32'(exp_v[1]));
    checkOutput("stuck4",   32'(stuck_b),  32'(exp_s[1]));
    checkOutput("high4",    32'(high_b),   32'(exp_h[1]));
    checkOutput("low4",     32'(low_b),    32'(exp_l[1]));
    checkOutput("period4",  32'(period_b), 32'(exp_p[1]));
  endtask

  // Holds sig_in at lvl for n clk edges, checking after each one
  task automatic applyStimulus(input logic lvl, input int n);
    repeat (n) begin
      sig_in = lvl;
      @(posedge clk);
      modelEdge();
      edge_num++;
      @(negedge clk);
      compareAll();
    end
  endtask

  task automatic runPeriods(input int h, input int l, input int n);
    repeat (n) begin
      applyStimulus(1'b1, h);
      applyStimulus(1'b0, l);
    end
  endtask

  // Directed scenarios first, then randomized phase lengths
  initial begin
    int h, l;
    rst_n  = 1'b0;
    sig_in = 1'b0;
    @(negedge clk);

    // Reset with a low input, then a 3/2 square wave
    applyStimulus(1'b0, 3);
    rst_n = 1'b1;
    applyStimulus(1'b0, 4);
    runPeriods(3, 2, 6);

    // Change of ratio at a rise
    runPeriods(2, 2, 4);
    runPeriods(7, 1, 4);

    // Fastest measurable input
    runPeriods(1, 1, 6);

    // Long high phase saturates the narrow instance, then recovery
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 2);
    runPeriods(3, 2, 4);

    // Input high across reset release must not give a partial measurement
    sig_in = 1'b1;
    rst_n  = 1'b0;
    applyStimulus(1'b1, 2);
    rst_n = 1'b1;
    applyStimulus(1'b1, 6);
    applyStimulus(1'b0, 4);
    runPeriods(4, 4, 4);

    // One-cycle reset pulse while the low phase is being timed
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 4);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1);
    rst_n = 1'b1;
    applyStimulus(1'b0, 3);
    runPeriods(3, 2, 4);

    // Random phase lengths, some long enough to saturate the WIDTH=4 copy,
    // with the occasional reset pulse
    repeat (40) begin
      h = $urandom_range(1, 12);
      l = $urandom_range(1, 12);
      if ($urandom_range(0, 7) == 0) h = $urandom_range(14, 20);
      if ($urandom_range(0, 7) == 0) l = $urandom_range(14, 20);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        applyStimulus(sig_in, 1);
        rst_n = 1'b1;
      end
      runPeriods(h, l, 1);
    end
    applyStimulus(1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/clk_meter.md
# clk_meter

Measures an incoming divided clock, such as a divider output driving an LED, in units of the system clock. It reports high time, low time and period as cycle counts, pulsing a valid strobe once per completed input period. It sits downstream of the team's clock dividers, either to verify a divide ratio on the board or to recover N from an unknown slow clock. It also flags an input that has stopped toggling.

## Interface
- WIDTH, default 16: width of the high and low phase counters. The maximum countable phase is 2**WIDTH-1 cycles.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset. Synchronous, active-low.
- sig_in  input  1  slow clock under measurement. It is asynchronous to clk.
- high_time  output  WIDTH  high-phase length of the last completed period, in clk cycles.
- low_time  output  WIDTH  low-phase length of the last completed period, in clk cycles.
- period  output  WIDTH+1  high_time+low_time of the last completed period. The extra bit means the sum never overflows.
- meas_valid  output  1  one-cycle pulse when high_time, low_time and period update.
- stuck  output  1  set when a phase counter saturates. Cleared on the next meas_valid.

## Operation
- Synchronizer: sig_in passes through s1 then s2. s3 is a delayed copy of s2.
  - rise = s2 & ~s3.
  - fall = ~s2 & s3.
  - All three flops reset to 0.
- Phase counters hcnt and lcnt, both WIDTH bits. MAX = 2**WIDTH-1.
- States:
  - SYNC, entered on reset. A 2-bit settle counter counts 3 cycles. After that, the block moves to WAIT_RISE on the first cycle with s2=0; otherwise it stays in SYNC. This prevents a high phase already in progress at reset from being measured as partial.
  - WAIT_RISE. On rise: hcnt<=1, go to MEAS_HIGH. fall is ignored.
  - MEAS_HIGH.
    - On fall: lcnt<=1, go to MEAS_LOW.
    - Else if hcnt==MAX: stuck<=1, go to WAIT_RISE.
    - Else: hcnt<=hcnt+1.
  - MEAS_LOW.
    - On rise: latch outputs (listed below), then hcnt<=1 and stay in the measuring loop by going to MEAS_HIGH.
    - Else if lcnt==MAX: stuck<=1, go to WAIT_RISE.
    - Else: lcnt<=lcnt+1.
- Outputs latched on a rise in MEAS_LOW:
  - high_time<=hcnt.
  - low_time<=lcnt.
  - period<=hcnt+lcnt, zero-extended to WIDTH+1 bits.
  - meas_valid<=1.
  - stuck<=0.
- For a steady input with H synchronized high cycles and L low cycles, the block reports high_time=H, low_time=L, period=H+L.
- rise and fall are mutually exclusive by construction. No simultaneous-event rule is needed.
- Outputs hold their last value between strobes. stuck does not alter high_time, low_time or period.
- Abort on saturation:
  - The block returns to WAIT_RISE, not SYNC.
  - A stuck-high input resumes on its next rise; the intervening fall is ignored.
  - A stuck-low input resumes on its next rise.
- Input phases shorter than one clk cycle may be missed. This is not an error condition.

## Timing
- Reset values, one edge after rst_n is sampled low:
  - high_time=0, low_time=0, period=0.
  - meas_valid=0, stuck=0.
  - State = SYNC, settle counter = 0, s1=s2=s3=0, hcnt=lcnt=0.
- Reset mid-operation discards any partial measurement. There is no meas_valid until a fresh SYNC to WAIT_RISE to MEAS_HIGH to MEAS_LOW to rise sequence completes.
- Latency: sig_in is first sampled high at edge k. rise is decoded between edges k+1 and k+2. meas_valid and the new values are visible after edge k+2.
- meas_valid lasts exactly one cycle. Strobes are spaced period cycles apart.
- The first valid strobe comes on the second rise after WAIT_RISE is entered.
- stuck is set on the edge after the counter reaches MAX without the expected edge. It stays high until the next meas_valid.

## Test plan
- Reset with sig_in=0, then a square wave driven on clk rising edges with H=3, L=2 -> first meas_valid on the 2nd rise reports 3/2/5 with stuck=0. Subsequent strobes come every 5 cycles.
- H=2, L=2, then switching to H=7, L=1 at a rise -> 2/2/4 strobes, then 7/1/8 from the first full new period. No intermediate garbage.
- H=1, L=1 -> 1/1/2 with meas_valid every 2 cycles.
- WIDTH=4, sig_in held high for 20 cycles after a valid period -> stuck=1 after hcnt reaches 15, with no meas_valid and outputs unchanged. Resuming H=3, L=2 -> first following strobe reports 3/2/5 and stuck=0.
- sig_in=1 at reset release, held for 6 cycles, then H=4, L=4 -> no strobe from the initial partial high phase. The first strobe reports 4/4/8.
- rst_n pulsed low for 1 cycle during MEAS_LOW -> all outputs are 0 after the next edge. The next strobe comes only after a complete new period.
